// File: rtl/edge_mac.sv
// Two-stage 3x3 multiply-accumulate for Sobel gradients: products, then sum.
// Define EDGE_MAC_SATURATE_EN to clamp the output and add the sat_flag port.
module edge_mac #(
    parameter int IMG_W  = 9,
    parameter int MASK_W = 3,
    parameter int OUT_W  = IMG_W + MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IMG_W-1:0]  Ai00_0,
    input  logic [IMG_W-1:0]  Ai01_0,
    input  logic [IMG_W-1:0]  Ai02_0,
    input  logic [IMG_W-1:0]  Ai10_0,
    input  logic [IMG_W-1:0]  Ai11_0,
    input  logic [IMG_W-1:0]  Ai12_0,
    input  logic [IMG_W-1:0]  Ai20_0,
    input  logic [IMG_W-1:0]  Ai21_0,
    input  logic [IMG_W-1:0]  Ai22_0,
    input  logic [MASK_W-1:0] Bi00_0,
    input  logic [MASK_W-1:0] Bi01_0,
    input  logic [MASK_W-1:0] Bi02_0,
    input  logic [MASK_W-1:0] Bi10_0,
    input  logic [MASK_W-1:0] Bi11_0,
    input  logic [MASK_W-1:0] Bi12_0,
    input  logic [MASK_W-1:0] Bi20_0,
    input  logic [MASK_W-1:0] Bi21_0,
    input  logic [MASK_W-1:0] Bi22_0,
    output logic [OUT_W-1:0]  fil_out_0,
    output logic              out_valid
`ifdef EDGE_MAC_SATURATE_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int PW = IMG_W + MASK_W + 1;
    localparam int SW = OUT_W + 4;

    logic [IMG_W-1:0]     a [9];
    logic [MASK_W-1:0]    b [9];
    logic signed [PW-1:0] prod [9];
    logic signed [PW-1:0] prod_q [9];
    logic signed [SW-1:0] sum;
    logic [OUT_W-1:0]     res;
    logic                 clamp;
    logic                 v1;

    assign a = '{Ai00_0, Ai01_0, Ai02_0,
                 Ai10_0, Ai11_0, Ai12_0,
                 Ai20_0, Ai21_0, Ai22_0};
    assign b = '{Bi00_0, Bi01_0, Bi02_0,
                 Bi10_0, Bi11_0, Bi12_0,
                 Bi20_0, Bi21_0, Bi22_0};

    // Pixels are unsigned, so zero-extend A; mask is signed.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod[i] = signed'({{(PW-IMG_W){1'b0}}, a[i]}) *
                      signed'({{(PW-MASK_W){b[i][MASK_W-1]}}, b[i]});
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + SW'(prod_q[i]);
        end
    end

`ifdef EDGE_MAC_SATURATE_EN
    logic over;
    logic under;

    // Out of range whenever the bits above the result sign disagree with it.
    assign over  = !sum[SW-1] && (|sum[SW-2:OUT_W-1]);
    assign under = sum[SW-1] && !(&sum[SW-2:OUT_W-1]);
    assign clamp = over || under;

    always_comb begin
        res = sum[OUT_W-1:0];
        if (over) res = {1'b0, {(OUT_W-1){1'b1}}};
        if (under) res = {1'b1, {(OUT_W-1){1'b0}}};
    end
`else
    logic unused_hi;

    assign unused_hi = ^sum[SW-1:OUT_W];
    assign clamp     = 1'b0;
    assign res       = sum[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            fil_out_0 <= '0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
`ifdef EDGE_MAC_SATURATE_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                for (int i = 0; i < 9; i++) prod_q[i] <= prod[i];
            end
            if (v1) fil_out_0 <= res;
`ifdef EDGE_MAC_SATURATE_EN
            sat_flag  <= v1 && clamp;
`endif
        end
    end

endmodule

// File: tb/tb_edge_mac.sv
// Directed and random bench for edge_mac against an arithmetic reference.
// Build with EDGE_MAC_SATURATE_EN to exercise the clamping variant.
module tb_edge_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [8:0]  ai [9];
    logic [2:0]  bi [9];
    logic [11:0] fil_out_0;
    logic        out_valid;
`ifdef EDGE_MAC_SATURATE_EN
    logic        sat_flag;
`endif

    int total = 0;
    int bad = 0;

    int pa [9];
    int pb [9];

    int SX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int SY [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    int FLAT [9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    int VERT [9] = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    int MIRR [9] = '{255, 0, 0, 255, 0, 0, 255, 0, 0};
    int HORZ [9] = '{255, 255, 255, 0, 0, 0, 0, 0, 0};

    typedef struct {
        bit          v;
        logic [11:0] r;
        bit          s;
    } ent_t;

    ent_t        pipe [$];
    bit          exp_ov;
    logic [11:0] exp_out;
    bit          exp_sat;

    edge_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .Ai00_0(ai[0]), .Ai01_0(ai[1]), .Ai02_0(ai[2]),
        .Ai10_0(ai[3]), .Ai11_0(ai[4]), .Ai12_0(ai[5]),
        .Ai20_0(ai[6]), .Ai21_0(ai[7]), .Ai22_0(ai[8]),
        .Bi00_0(bi[0]), .Bi01_0(bi[1]), .Bi02_0(bi[2]),
        .Bi10_0(bi[3]), .Bi11_0(bi[4]), .Bi12_0(bi[5]),
        .Bi20_0(bi[6]), .Bi21_0(bi[7]), .Bi22_0(bi[8]),
        .fil_out_0(fil_out_0),
        .out_valid(out_valid)
`ifdef EDGE_MAC_SATURATE_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int av [9], input int bv [9]);
        for (int i = 0; i < 9; i++) begin
            pa[i] = av[i];
            pb[i] = bv[i];
        end
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < 9; i++) begin
            pa[i] = av;
            pb[i] = bv;
        end
    endtask

    // Expected converted result of the current window, straight from the math.
    function automatic ent_t ref_of(input bit v);
        ent_t e;
        int   s;
        s = 0;
        for (int i = 0; i < 9; i++) s += pa[i] * pb[i];
        e.v = v;
        e.s = 1'b0;
        e.r = s[11:0];
`ifdef EDGE_MAC_SATURATE_EN
        if (s > 2047) begin
            e.r = 12'h7FF;
            e.s = 1'b1;
        end else if (s < -2048) begin
            e.r = 12'h800;
            e.s = 1'b1;
        end
`endif
        return e;
    endfunction

    // One clock: drive, step the reference (2-cycle latency), compare.
    task automatic cycle(input bit v, input bit r);
        ent_t e;
        rst      = r;
        in_valid = v;
        for (int i = 0; i < 9; i++) begin
            ai[i] = pa[i][8:0];
            bi[i] = pb[i][2:0];
        end
        @(posedge clk);
        #1;
        if (r) begin
            pipe.delete();
            pipe.push_back('{v: 1'b0, r: 12'h0, s: 1'b0});
            exp_ov  = 1'b0;
            exp_out = 12'h0;
            exp_sat = 1'b0;
        end else begin
            pipe.push_back(ref_of(v));
            e = pipe.pop_front();
            exp_ov  = e.v;
            exp_sat = e.v && e.s;
            if (e.v) exp_out = e.r;
        end
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("fil_out_0", 32'(fil_out_0), 32'(exp_out));
`ifdef EDGE_MAC_SATURATE_EN
        chk("sat_flag", 32'(sat_flag), 32'(exp_sat));
`endif
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        fill(0, 0);
        cycle(0, 1);
        cycle(0, 1);
        chk("rst_fil", 32'(fil_out_0), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        cycle(0, 0);

        load(FLAT, SX);
        cycle(1, 0);
        chk("lat1_ov", 32'(out_valid), 32'h0);
        cycle(0, 0);
        chk("flat_x", 32'(fil_out_0), 32'h0);
        cycle(0, 0);
        chk("pulse_ov", 32'(out_valid), 32'h0);
        load(FLAT, SY);
        cycle(1, 0);
        cycle(0, 0);
        chk("flat_y", 32'(fil_out_0), 32'h0);

        load(VERT, SX);
        cycle(1, 0);
        cycle(0, 0);
        chk("vert", 32'(fil_out_0), 32'h3FC);
        load(MIRR, SX);
        cycle(1, 0);
        cycle(0, 0);
        chk("mirr", 32'(fil_out_0), 32'hC04);
        load(HORZ, SY);
        cycle(1, 0);
        cycle(0, 0);
        chk("horz", 32'(fil_out_0), 32'h3FC);

        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) load(VERT, SX);
            else load(MIRR, SX);
            cycle(1, 0);
        end
        for (int k = 0; k < 3; k++) cycle(0, 0);
        chk("hold", 32'(fil_out_0), 32'hC04);
        chk("idle_ov", 32'(out_valid), 32'h0);

        load(VERT, SX);
        cycle(1, 0);
        cycle(0, 1);
        cycle(0, 0);
        chk("rstmid_ov", 32'(out_valid), 32'h0);
        chk("rstmid_fil", 32'(fil_out_0), 32'h0);
        cycle(1, 0);
        cycle(0, 0);
        chk("after_rst", 32'(fil_out_0), 32'h3FC);

        fill(511, -4);
        cycle(1, 0);
        cycle(0, 0);
`ifdef EDGE_MAC_SATURATE_EN
        chk("ovf_neg", 32'(fil_out_0), 32'h800);
`else
        chk("ovf_neg", 32'(fil_out_0), 32'h824);
`endif
        fill(511, 3);
        cycle(1, 0);
        cycle(0, 0);
`ifdef EDGE_MAC_SATURATE_EN
        chk("ovf_pos", 32'(fil_out_0), 32'h7FF);
`else
        chk("ovf_pos", 32'(fil_out_0), 32'h5E5);
`endif

        fill(0, 0);
        pa[0] = 511;
        pb[0] = -1;
        cycle(1, 0);
        cycle(0, 0);
        chk("unsigned", 32'(fil_out_0), 32'hE01);

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 9; i++) begin
                pa[i] = int'($urandom_range(511));
                pb[i] = int'($urandom_range(7)) - 4;
            end
            if ($urandom_range(9) == 0) fill(511, ($urandom_range(1) == 0) ? -4 : 3);
            cycle($urandom_range(3) != 0, $urandom_range(49) == 0);
        end
        cycle(0, 0);
        cycle(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edge_mac.md
Name: edge_mac

Overview:
- Pipelined 3x3 multiply-accumulate kernel for the Sobel edge detector.
- Takes a 3x3 pixel window (A) and a 3x3 signed mask (B), and produces the registered dot product on fil_out_0.
- Two instances, one per mask (Gx, Gy), sit behind the row-buffer/window logic; results feed the gradient output stage.

Parameters:
- IMG_W, 9, pixel input width; unsigned, zero-extended.
- MASK_W, 3, mask coefficient width; two's-complement signed.
- OUT_W, IMG_W+MASK_W (12), result width; two's-complement signed.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  window/mask inputs valid this cycle.
- Ai00_0..Ai22_0  in  IMG_W each  pixel window, row r column c as Airc_0 (00 top-left, 22 bottom-right).
- Bi00_0..Bi22_0  in  MASK_W each  mask coefficients, same indexing; signed.
- fil_out_0  out  OUT_W  signed sum over r,c of Airc*Birc.
- out_valid  out  1  fil_out_0 updated with a new result this cycle.

Behaviour:
- Reset: synchronous, active-high. On any rising edge with rst=1, all pipeline registers clear: fil_out_0=0, out_valid=0. Reset overrides in_valid. An in-flight result is discarded, and no out_valid follows the reset.
- Stage 1 (edge after in_valid=1):
  - Register the nine products Airc*Birc.
  - A is zero-extended to IMG_W+1 bits; B is sign-extended.
  - Each product is signed and exact (IMG_W+MASK_W+1 bits).
- Stage 2 (next edge): register the sum of the nine products in a full-precision signed accumulator of OUT_W+4 bits (no internal overflow possible).
- Output conversion: full sum -> fil_out_0 as the low OUT_W bits (two's-complement wrap) unless EDGE_MAC_SATURATE_EN is defined.
- Latency: fixed 2 cycles. in_valid=1 at edge N gives out_valid=1 and the new fil_out_0 after edge N+2.
- Throughput: one window per cycle; back-to-back valids give back-to-back results with no bubbles.
- Valid pipeline: a 2-deep shift of in_valid. A stage register loads only when its incoming valid bit is 1, otherwise it holds. fil_out_0 therefore holds the last result while out_valid=0.
- Mask inputs: sampled together with A on the same in_valid edge. Mask changes between windows are legal; there is no mask caching.
- Arithmetic is symmetric between Gx and Gy usage; the block has no knowledge of which mask is applied.
- Sign reference values:
  - B = 3'b111 means -1; 3'b110 means -2.
  - A = 9'h1FF means +511, not -1.
- Boundary sums:
  - Max positive full sum: 9*511*3 = 13797.
  - Min full sum: 9*511*(-4) = -18396.
  - Both exceed OUT_W and are handled per the output conversion rule.

Optional Feature:
- Macro EDGE_MAC_SATURATE_EN.
- Defined: the stage-2 result clamps to the OUT_W signed range. Sums above 2^(OUT_W-1)-1 give 12'h7FF (2047); sums below -2^(OUT_W-1) give 12'h800 (-2048). Adds one output register bit sat_flag (out, 1) that is high alongside out_valid when clamping occurred, and 0 on reset.
- Undefined: wrap (truncate to the low OUT_W bits); the sat_flag port does not exist.
- Latency is identical in both builds.

Test Plan:
- Flat window, all A=2, Sobel-x mask (-1,0,1 / -2,0,2 / -1,0,1), one in_valid pulse -> out_valid exactly 2 cycles later, fil_out_0=0. Same with Sobel-y mask (1,2,1 / 0,0,0 / -1,-2,-1) -> 0.
- Vertical edge: left column A=0, right column A=255, Sobel-x -> fil_out_0=12'h3FC (1020). Mirrored (left 255, right 0) -> 12'hC04 (-1020). Horizontal edge (top 255, bottom 0) with Sobel-y -> 1020.
- Streaming: 4 consecutive valid windows with alternating edge directions -> 4 consecutive out_valid cycles with 1020, -1020, 1020, -1020 in order. Then in_valid=0 -> out_valid=0, and fil_out_0 holds -1020.
- Reset mid-operation: in_valid pulse, then rst=1 on the next edge -> out_valid never asserts, fil_out_0=0. After rst drops, a new window gives its result 2 cycles later.
- Overflow: all A=511, all B=-4 (3'b100) -> wrap build gives 12'h824 (2084). Saturate build gives 12'h800 with sat_flag=1. All A=511, all B=3 -> wrap 12'h5E5 (1509); saturate 12'h7FF, sat_flag=1.
- Unsigned pixel check: A00=511, B00=-1, all others 0 -> fil_out_0=12'hE01 (-511), not +1.
